// File: rtl/quaddemux_pkg.sv
// Shared constants and channel-select type for the quad 64-bit demux buffer.
package quaddemux_pkg;

   localparam int unsigned DataWidth = 64;
   localparam int unsigned NumCh     = 4;
   localparam int unsigned CntWidth  = 8;

   typedef enum logic [1:0] {
      CH_A = 2'd0,
      CH_B = 2'd1,
      CH_C = 2'd2,
      CH_D = 2'd3
   } chSel_e;

endpackage

// File: rtl/demux_fifo.sv
// Single-channel DEPTH-entry FIFO; head word is presented combinationally from storage.
module demux_fifo
   import quaddemux_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 push,
   input  logic                 pop,
   input  logic [DataWidth-1:0] dataIn,
   output logic [DataWidth-1:0] dataOut,
   output logic                 full,
   output logic                 empty
);

   localparam int unsigned      PtrW    = $clog2(DEPTH);
   localparam logic [PtrW:0]    FullOcc = (PtrW + 1)'(DEPTH);
   localparam logic [PtrW-1:0]  PtrOne  = 1;
   localparam logic [PtrW:0]    OccOne  = 1;

   logic [DataWidth-1:0] mem [DEPTH];
   logic [PtrW-1:0]      wrPtr;
   logic [PtrW-1:0]      rdPtr;
   logic [PtrW:0]        occ;
   logic                 doPush;
   logic                 doPop;

   assign full    = (occ == FullOcc);
   assign empty   = (occ == '0);
   assign doPush  = push & ~full;
   assign doPop   = pop & ~empty;
   assign dataOut = mem[rdPtr];

   // Extra occupancy bit separates full from empty when the pointers coincide.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wrPtr <= '0;
         rdPtr <= '0;
         occ   <= '0;
      end else begin
         if (doPush) wrPtr <= wrPtr + PtrOne;
         if (doPop)  rdPtr <= rdPtr + PtrOne;
         case ({doPush, doPop})
            2'b10:   occ <= occ + OccOne;
            2'b01:   occ <= occ - OccOne;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem <= '{default: '0};
      end else if (doPush) begin
         mem[wrPtr] <= dataIn;
      end
   end

endmodule

// File: rtl/quaddemux_64bit_buf.sv
// Routes 64-bit words into one of four buffered output channels selected by S.
// Optional per-channel delivered-word counters are enabled with QDEMUX_CNT_EN.
module quaddemux_64bit_buf
   import quaddemux_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DataWidth-1:0] In,
   input  logic [1:0]           S,
   input  logic                 InValid,
   output logic                 InReady,
   output logic [DataWidth-1:0] OutA,
   output logic [DataWidth-1:0] OutB,
   output logic [DataWidth-1:0] OutC,
   output logic [DataWidth-1:0] OutD,
   output logic [NumCh-1:0]     OutValid,
   input  logic [NumCh-1:0]     OutReady
`ifdef QDEMUX_CNT_EN
   ,
   output logic [31:0]          Count
`endif
);

   logic [NumCh-1:0]     selVec;
   logic [NumCh-1:0]     full;
   logic [NumCh-1:0]     empty;
   logic [NumCh-1:0]     pushVec;
   logic [NumCh-1:0]     popVec;
   logic [DataWidth-1:0] headData [NumCh];

   always_comb begin
      selVec = '0;
      unique case (chSel_e'(S))
         CH_A: selVec = 4'b0001;
         CH_B: selVec = 4'b0010;
         CH_C: selVec = 4'b0100;
         CH_D: selVec = 4'b1000;
      endcase
   end

   // Readiness looks only at the selected channel's fullness, never at OutReady.
   assign InReady  = ~|(full & selVec);
   assign pushVec  = selVec & {NumCh{InValid & InReady}};
   assign popVec   = OutReady & ~empty;
   assign OutValid = ~empty;

   for (genvar i = 0; i < NumCh; i++) begin : gChan
      demux_fifo #(
         .DEPTH (DEPTH)
      ) uFifo (
         .clk     (clk),
         .rst     (rst),
         .push    (pushVec[i]),
         .pop     (popVec[i]),
         .dataIn  (In),
         .dataOut (headData[i]),
         .full    (full[i]),
         .empty   (empty[i])
      );
   end

   assign OutA = headData[CH_A];
   assign OutB = headData[CH_B];
   assign OutC = headData[CH_C];
   assign OutD = headData[CH_D];

`ifdef QDEMUX_CNT_EN
   logic [CntWidth-1:0] cnt [NumCh];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '{default: '0};
      end else begin
         for (int i = 0; i < NumCh; i++) begin
            if (popVec[i] && (cnt[i] != '1)) cnt[i] <= cnt[i] + CntWidth'(1);
         end
      end
   end

   always_comb begin
      Count = '0;
      for (int i = 0; i < NumCh; i++) Count[CntWidth*i +: CntWidth] = cnt[i];
   end
`endif

endmodule
